// File: rtl/emgc_ctrl_n_pkg.sv
// Shared types and constants for the N-channel serial-link emergency controller.
package emgc_ctrl_n_pkg;

    localparam int RETRY_W          = 4;
    localparam int GUARD_CYCLES_DEF = 5000;
    localparam int CNT_W_DEF        = 13;

    localparam int CH_SR  = 0;
    localparam int CH_DPR = 1;
    localparam int CH_CCW = 2;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_REPEAT,
        RESP_TOGGLE
    } resp_e;

    // A channel that has used up its repeats escalates to a source toggle.
    function automatic resp_e pick_response(input logic fire, input logic can_retry);
        if (!fire)
            return RESP_NONE;
        return can_retry ? RESP_REPEAT : RESP_TOGGLE;
    endfunction

endpackage

// File: rtl/emgc_ctrl_n_guard_timer.sv
// Shared retriggerable guard delay: expired is high in the cycle the count reaches GUARD_CYCLES-1.
module guard_timer #(
    parameter int GUARD_CYCLES = 5000,
    parameter int CNT_W        = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    assign busy    = busy_q;
    assign expired = busy_q && (cnt_q == CNT_W'(GUARD_CYCLES - 1));

    // A start in the expiry cycle wins, so a late failure re-arms the delay.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (expired) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/emgc_ctrl_n.sv
// N-channel emergency controller: reply ownership, fault detection, guarded repeat and
// source-toggle escalation between the command scheduler and the rx deserialiser.
module emgc_ctrl_n
    import emgc_ctrl_n_pkg::*;
#(
    parameter int N            = 3,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int MAX_RETRIES  = 2,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         cmd_accepted,
    input  logic [N-1:0]         reply_window,
    input  logic                 rx_start_bit,
    input  logic                 rx_frame_end,
    input  logic                 rx_err,
    input  logic                 rx_busy,
    output logic [N-1:0]         repeat_req,
    output logic [N-1:0]         toggle_src_req,
    output logic [N-1:0]         owner,
    output logic [RETRY_W*N-1:0] retry_cnt
);

    logic [N-1:0] win_prev_q;
    logic [N-1:0] owner_q, owner_d;
    logic [N-1:0] repeat_q, repeat_d;
    logic [N-1:0] toggle_q, toggle_d;
    logic [N-1:0] fail;
    logic         timer_busy, timer_expired, expiry;

    assign repeat_req     = repeat_q;
    assign toggle_src_req = toggle_q;
    assign owner          = owner_q;

    guard_timer #(
        .GUARD_CYCLES (GUARD_CYCLES),
        .CNT_W        (CNT_W)
    ) u_guard_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (|fail),
        .busy    (timer_busy),
        .expired (timer_expired)
    );

    assign expiry = timer_expired & timer_busy;

    // Lowest set window bit wins; x & (~x + 1) isolates it.
    always_comb begin
        owner_d = owner_q;
        if (rx_frame_end)
            owner_d = '0;
        if (rx_start_bit && (reply_window != '0))
            owner_d = reply_window & (~reply_window + N'(1));
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic               frame_done, busy_rep, success, fire_window, can_retry;
        logic               pending_q, pending_d;
        logic [RETRY_W-1:0] retry_q, retry_d;
        resp_e              resp;

        assign frame_done  = owner_q[gi] & rx_frame_end;
        assign fail[gi]    = (win_prev_q[gi] & ~reply_window[gi] & ~owner_q[gi])
                           | (frame_done & rx_err);
        assign busy_rep    = frame_done & ~rx_err & rx_busy;
        assign success     = frame_done & ~rx_err & ~rx_busy;
        assign fire_window = expiry & pending_q & ~fail[gi];
        assign can_retry   = retry_q < RETRY_W'(MAX_RETRIES);
        assign resp        = pick_response(fire_window & ~cmd_accepted[gi], can_retry);

        // A fresh command on the expiry cycle cancels the response and the history.
        always_comb begin
            pending_d = pending_q;
            retry_d   = retry_q;
            if (fire_window) begin
                if (resp == RESP_REPEAT)
                    retry_d = retry_q + RETRY_W'(1);
                else
                    retry_d = '0;
            end else if (success) begin
                retry_d = '0;
            end
            if (expiry)
                pending_d = 1'b0;
            if (fail[gi])
                pending_d = 1'b1;
        end

        assign repeat_d[gi] = (busy_rep | (resp == RESP_REPEAT)) & (resp != RESP_TOGGLE);
        assign toggle_d[gi] = (resp == RESP_TOGGLE);
        assign retry_cnt[RETRY_W*gi +: RETRY_W] = retry_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pending_q <= 1'b0;
                retry_q   <= '0;
            end else begin
                pending_q <= pending_d;
                retry_q   <= retry_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_prev_q <= '0;
            owner_q    <= '0;
            repeat_q   <= '0;
            toggle_q   <= '0;
        end else begin
            win_prev_q <= reply_window;
            owner_q    <= owner_d;
            repeat_q   <= repeat_d;
            toggle_q   <= toggle_d;
        end
    end

endmodule

// File: tb/tb_emgc_ctrl_n.sv
// Directed scenarios plus randomized traffic against a cycle-numbered behavioural model.
module tb_emgc_ctrl_n;

    localparam int N    = 3;
    localparam int G    = 10;
    localparam int MAXR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  cmd_accepted = '0;
    logic [N-1:0]  reply_window = '0;
    logic          rx_start_bit = 1'b0;
    logic          rx_frame_end = 1'b0;
    logic          rx_err = 1'b0;
    logic          rx_busy = 1'b0;
    logic [N-1:0]  repeat_req, toggle_src_req, owner;
    logic [4*N-1:0] retry_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: expiry is the absolute cycle number at which the guard runs out.
    int           cyc = 0;
    int           m_owner;
    logic [N-1:0] m_prev;
    bit           m_pend [N];
    int           m_retry [N];
    int           m_exp_at;
    logic [N-1:0] e_rep, e_tog;

    emgc_ctrl_n #(
        .N            (N),
        .GUARD_CYCLES (G),
        .MAX_RETRIES  (MAXR),
        .CNT_W        (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_accepted   (cmd_accepted),
        .reply_window   (reply_window),
        .rx_start_bit   (rx_start_bit),
        .rx_frame_end   (rx_frame_end),
        .rx_err         (rx_err),
        .rx_busy        (rx_busy),
        .repeat_req     (repeat_req),
        .toggle_src_req (toggle_src_req),
        .owner          (owner),
        .retry_cnt      (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner  = -1;
        m_prev   = '0;
        m_exp_at = -1;
        e_rep    = '0;
        e_tog    = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i]  = 1'b0;
            m_retry[i] = 0;
        end
    endtask

    task automatic model_step();
        bit           fail [N];
        bit           expd, anyfail, mine, fired;
        logic [N-1:0] nrep, ntog;
        expd = (m_exp_at == cyc);
        nrep = '0;
        ntog = '0;
        anyfail = 1'b0;
        for (int i = 0; i < N; i++) begin
            mine    = (m_owner == i) && rx_frame_end;
            fail[i] = (m_prev[i] && !reply_window[i] && m_owner != i) || (mine && rx_err);
            fired   = expd && m_pend[i] && !fail[i];
            if (mine && !rx_err && rx_busy)
                nrep[i] = 1'b1;
            if (fired) begin
                if (cmd_accepted[i]) begin
                    m_retry[i] = 0;
                end else if (m_retry[i] < MAXR) begin
                    nrep[i] = 1'b1;
                    m_retry[i]++;
                end else begin
                    ntog[i] = 1'b1;
                    nrep[i] = 1'b0;
                    m_retry[i] = 0;
                end
            end else if (mine && !rx_err && !rx_busy) begin
                m_retry[i] = 0;
            end
            if (expd)
                m_pend[i] = 1'b0;
            if (fail[i]) begin
                m_pend[i] = 1'b1;
                anyfail = 1'b1;
            end
        end
        if (anyfail)
            m_exp_at = cyc + G;
        else if (expd)
            m_exp_at = -1;
        if (rx_start_bit && reply_window != '0) begin
            for (int i = N - 1; i >= 0; i--)
                if (reply_window[i])
                    m_owner = i;
        end else if (rx_frame_end) begin
            m_owner = -1;
        end
        m_prev = reply_window;
        e_rep = nrep;
        e_tog = ntog;
    endtask

    function automatic logic [N-1:0] exp_owner();
        return (m_owner < 0) ? '0 : N'(1 << m_owner);
    endfunction

    function automatic logic [4*N-1:0] exp_retry();
        logic [4*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[4*i +: 4] = 4'(m_retry[i]);
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        cmd_accepted = '0;
        rx_start_bit = 1'b0;
        rx_frame_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_accepted = '0;
        reply_window = '0;
        rx_start_bit = 1'b0;
        rx_frame_end = 1'b0;
        rx_err = 1'b0;
        rx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One no-reply failure on channel ch, then wait out the guard delay.
    task automatic no_reply_fail(input int ch);
        reply_window = N'(1 << ch);
        repeat (2) tick();
        reply_window = '0;
        repeat (G + 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (repeat_req !== '0) $display("FAIL reset_repeat got=%b want=000", repeat_req); else n_pass++;
        n_checks++; if (toggle_src_req !== '0) $display("FAIL reset_toggle got=%b want=000", toggle_src_req); else n_pass++;
        n_checks++; if (owner !== '0) $display("FAIL reset_owner got=%b want=000", owner); else n_pass++;
        n_checks++; if (retry_cnt !== '0) $display("FAIL reset_retry got=%h want=000", retry_cnt); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_no_reply();
        logic [N-1:0] want;
        do_reset();
        reply_window = 3'b100;
        repeat (5) tick();
        reply_window = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            want = (k == 11) ? 3'b100 : 3'b000;
            n_checks++;
            if (repeat_req !== want) $display("FAIL no_reply_rep k=%0d got=%b want=%b", k, repeat_req, want);
            else n_pass++;
        end
        n_checks++;
        if (retry_cnt[11:8] !== 4'd1) $display("FAIL no_reply_retry got=%0d want=1", retry_cnt[11:8]);
        else n_pass++;
        $display("test_no_reply done");
    endtask

    task automatic test_escalation();
        logic [3:0] want_cnt;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            reply_window = 3'b010;
            repeat (2) tick();
            reply_window = '0;
            for (int k = 1; k <= 11; k++) begin
                tick();
                if (k < 11) begin
                    n_checks++;
                    if ((repeat_req | toggle_src_req) !== '0)
                        $display("FAIL esc_early r=%0d k=%0d rep=%b tog=%b want=000", r, k, repeat_req, toggle_src_req);
                    else n_pass++;
                end
            end
            want_cnt = (r == 0) ? 4'd1 : (r == 1) ? 4'd2 : 4'd0;
            n_checks++;
            if (repeat_req !== ((r < 2) ? 3'b010 : 3'b000)) $display("FAIL esc_rep r=%0d got=%b", r, repeat_req);
            else n_pass++;
            n_checks++;
            if (toggle_src_req !== ((r == 2) ? 3'b010 : 3'b000)) $display("FAIL esc_tog r=%0d got=%b", r, toggle_src_req);
            else n_pass++;
            n_checks++;
            if (retry_cnt[7:4] !== want_cnt) $display("FAIL esc_cnt r=%0d got=%0d want=%0d", r, retry_cnt[7:4], want_cnt);
            else n_pass++;
        end
        $display("test_escalation done");
    endtask

    task automatic test_error_frame();
        logic [N-1:0] want;
        do_reset();
        reply_window = 3'b001;
        tick();
        rx_start_bit = 1'b1;
        tick();
        reply_window = '0;
        n_checks++; if (owner !== 3'b001) $display("FAIL err_owner got=%b want=001", owner); else n_pass++;
        repeat (2) tick();
        n_checks++; if (owner !== 3'b001) $display("FAIL err_owner_hold got=%b want=001", owner); else n_pass++;
        rx_frame_end = 1'b1;
        rx_err = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rx_err = 1'b0;
            if (k == 1) begin
                n_checks++; if (owner !== '0) $display("FAIL err_owner_clr got=%b want=000", owner); else n_pass++;
            end
            want = (k == 11) ? 3'b001 : 3'b000;
            n_checks++;
            if (repeat_req !== want) $display("FAIL err_rep k=%0d got=%b want=%b", k, repeat_req, want);
            else n_pass++;
        end
        $display("test_error_frame done");
    endtask

    task automatic test_busy();
        do_reset();
        no_reply_fail(2);
        tick();
        reply_window = 3'b100;
        tick();
        rx_start_bit = 1'b1;
        tick();
        n_checks++; if (owner !== 3'b100) $display("FAIL busy_owner got=%b want=100", owner); else n_pass++;
        rx_frame_end = 1'b1;
        rx_busy = 1'b1;
        tick();
        rx_busy = 1'b0;
        n_checks++; if (repeat_req !== 3'b100) $display("FAIL busy_rep got=%b want=100", repeat_req); else n_pass++;
        n_checks++; if (retry_cnt[11:8] !== 4'd1) $display("FAIL busy_cnt got=%0d want=1", retry_cnt[11:8]); else n_pass++;
        tick();
        n_checks++; if (repeat_req !== '0) $display("FAIL busy_rep_end got=%b want=000", repeat_req); else n_pass++;
        $display("test_busy done");
    endtask

    task automatic test_overlap();
        logic [N-1:0] want;
        do_reset();
        reply_window = 3'b011;
        repeat (2) tick();
        reply_window = 3'b010;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 5)
                reply_window = '0;
            want = (k == 16) ? 3'b011 : 3'b000;
            n_checks++;
            if (repeat_req !== want) $display("FAIL overlap_rep k=%0d got=%b want=%b", k, repeat_req, want);
            else n_pass++;
        end
        $display("test_overlap done");
    endtask

    task automatic test_cmd_on_expiry();
        do_reset();
        no_reply_fail(0);
        tick();
        reply_window = 3'b011;
        repeat (2) tick();
        reply_window = '0;
        repeat (10) tick();
        cmd_accepted = 3'b001;
        tick();
        n_checks++; if (repeat_req !== 3'b010) $display("FAIL cmdexp_rep got=%b want=010", repeat_req); else n_pass++;
        n_checks++; if (toggle_src_req !== '0) $display("FAIL cmdexp_tog got=%b want=000", toggle_src_req); else n_pass++;
        n_checks++; if (retry_cnt[3:0] !== 4'd0) $display("FAIL cmdexp_cnt0 got=%0d want=0", retry_cnt[3:0]); else n_pass++;
        n_checks++; if (retry_cnt[7:4] !== 4'd1) $display("FAIL cmdexp_cnt1 got=%0d want=1", retry_cnt[7:4]); else n_pass++;
        $display("test_cmd_on_expiry done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        no_reply_fail(2);
        reply_window = 3'b100;
        repeat (2) tick();
        reply_window = '0;
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        n_checks++; if (retry_cnt !== '0) $display("FAIL rstmid_cnt got=%h want=000", retry_cnt); else n_pass++;
        n_checks++; if ((repeat_req | toggle_src_req | owner) !== '0)
            $display("FAIL rstmid_out rep=%b tog=%b own=%b want=000", repeat_req, toggle_src_req, owner);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++;
            if ((repeat_req | toggle_src_req) !== '0)
                $display("FAIL rstmid_after k=%0d rep=%b tog=%b want=000", k, repeat_req, toggle_src_req);
            else n_pass++;
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) reply_window[i] = ~reply_window[i];
                cmd_accepted[i] = ($urandom_range(19) == 0);
            end
            rx_start_bit = ($urandom_range(9) == 0);
            rx_frame_end = ($urandom_range(5) == 0);
            rx_err  = $urandom_range(1);
            rx_busy = $urandom_range(1);
            tick();
            n_checks++; if (repeat_req !== e_rep) $display("FAIL rand_rep t=%0d got=%b want=%b", t, repeat_req, e_rep); else n_pass++;
            n_checks++; if (toggle_src_req !== e_tog) $display("FAIL rand_tog t=%0d got=%b want=%b", t, toggle_src_req, e_tog); else n_pass++;
            n_checks++; if (owner !== exp_owner()) $display("FAIL rand_owner t=%0d got=%b want=%b", t, owner, exp_owner()); else n_pass++;
            n_checks++; if (retry_cnt !== exp_retry()) $display("FAIL rand_cnt t=%0d got=%h want=%h", t, retry_cnt, exp_retry()); else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_reply();
        test_escalation();
        test_error_frame();
        test_busy();
        test_overlap();
        test_cmd_on_expiry();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
